instr_fetch: RTL and testbench

Instruction fetch initiator for the riscv32i core: owns the program counter, drives the read side of the instruction ROM and buffers fetched words for decode. The ROM is a purely combinational responder, so the word returned for the driven address is captured on the same clock edge. Fetched {pc, instr} pairs are queued in a 2-entry buffer and handed to decode over a valid/ready handshake. A redirect from execute (branch/jump) flushes the buffer and reloads the PC.

---
 rtl/instr_fetch_pkg.sv | 11 +
 rtl/instr_fetch_if.sv | 39 +++
 rtl/instr_fetch_buffer.sv | 68 ++++++
 rtl/instr_fetch.sv | 60 ++++++
 tb/tb_instr_fetch.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and sizing for the instruction fetch slice.
package fetch_pkg;
    localparam int FETCH_DEPTH = 2;
    localparam int INSTR_BYTES = 4;
    localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: ROM read port, redirect input and decode handshake.
interface instr_fetch_if;
    logic        fetch_en;
    logic        rom_en;
    logic [30:0] rom_address;
    logic [31:0] rom_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        input  fetch_en,
        output rom_en,
        output rom_address,
        input  rom_instr,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        output fetch_en,
        input  rom_en,
        input  rom_address,
        output rom_instr,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Small shift FIFO of fetched {pc, instr}; slot 0 is the registered head.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fetch_entry_t     head
);
    fetch_entry_t     mem_reg  [FETCH_DEPTH];
    fetch_entry_t     mem_next [FETCH_DEPTH];
    fetch_entry_t     shifted  [FETCH_DEPTH];
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_idx;

    // Vacated slots are zeroed so the head reads 0 whenever the buffer is empty.
    assign wr_idx = count_reg - CNT_W'(pop);

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_DEPTH; gi++) begin : g_entry
            if (gi == FETCH_DEPTH - 1) begin : g_top
                assign shifted[gi] = pop ? '0 : mem_reg[gi];
            end else begin : g_mid
                assign shifted[gi] = pop ? mem_reg[gi+1] : mem_reg[gi];
            end

            always_comb begin
                if (flush)
                    mem_next[gi] = '0;
                else if (push && (wr_idx == CNT_W'(gi)))
                    mem_next[gi] = din;
                else
                    mem_next[gi] = shifted[gi];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    mem_reg[gi] <= '0;
                else
                    mem_reg[gi] <= mem_next[gi];
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        if (flush)
            count_next = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign count      = count_reg;
    assign head_valid = (count_reg != '0);
    assign head       = mem_reg[0];
endmodule

// File: rtl/instr_fetch.sv
// PC owner and ROM read initiator; feeds decode through a 2-deep buffer.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    logic [31:0]      pc_reg;
    logic [31:0]      pc_next;
    logic [CNT_W-1:0] count;
    logic             head_valid;
    fetch_entry_t     head;
    fetch_entry_t     din;
    logic             pop;
    logic             space;
    logic             push;

    // A pop frees a slot in the same cycle, so a full buffer still streams.
    assign pop   = head_valid & bus.instr_ready;
    assign space = (count < CNT_W'(FETCH_DEPTH)) | pop;
    assign push  = bus.fetch_en & space & ~bus.redirect_valid & ~reset;

    assign bus.rom_en      = push;
    assign bus.rom_address = pc_reg[30:0];
    assign din             = '{pc: pc_reg, instr: bus.rom_instr};

    always_comb begin
        pc_next = pc_reg;
        if (bus.redirect_valid)
            pc_next = bus.redirect_pc & ~32'h0000_0003;
        else if (push)
            pc_next = pc_reg + 32'(INSTR_BYTES);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_reg <= RESET_PC;
        else
            pc_reg <= pc_next;
    end

    fetch_buffer u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop & ~bus.redirect_valid),
        .flush      (bus.redirect_valid),
        .din        (din),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign bus.instr_valid = head_valid;
    assign bus.instr_data  = head.instr;
    assign bus.instr_pc    = head.pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, corner sequences, random vs queue model.
module tb_instr_fetch;
    logic clk;
    logic reset;
    bit   rom_mode;
    bit   wrap_en;
    int   n_cmp;
    int   n_err;

    instr_fetch_if bus ();
    instr_fetch_if wbus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [30:0] a, input bit mode);
        if (mode)
            return ({1'b0, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
        case (a)
            31'h0:   return 32'h8000_0337;
            31'h4:   return 32'h0003_03E7;
            default: return 32'h0;
        endcase
    endfunction

    always_comb bus.rom_instr  = rom_word(bus.rom_address, rom_mode);
    always_comb wbus.rom_instr = rom_word(wbus.rom_address, 1'b0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst_before;
        bit          en;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        bit          e_rom_en;
        logic [30:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rb, input bit en, input bit rdy, input bit ev,
                       input logic [31:0] epc, input logic [31:0] ed,
                       input bit er, input logic [30:0] ea);
        vec_t v;
        v.rst_before = rb;  v.en = en;  v.rdy = rdy;  v.e_valid = ev;
        v.e_pc = epc;  v.e_data = ed;  v.e_rom_en = er;  v.e_addr = ea;
        tbl.push_back(v);
    endtask

    // Random-phase reference model: a plain FIFO of fetched pairs plus a PC.
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [31:0] m_pc;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rom_mode = 1'b0;
        wrap_en  = 1'b0;
        reset = 1'b1;
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        wbus.fetch_en = 1'b0;
        wbus.instr_ready = 1'b1;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc = 32'h0;

        // Reset state while fetch_en is already high
        #1;
        chk("reset_valid", 32'(bus.instr_valid), 32'h0);
        chk("reset_data", bus.instr_data, 32'h0);
        chk("reset_pc", bus.instr_pc, 32'h0);
        chk("reset_rom_en", 32'(bus.rom_en), 32'h0);
        next_cycle();
        reset = 1'b0;

        // Free run, ready held high
        add(1, 1, 1, 0, 32'h0, 32'h0,         1, 31'h0);
        add(0, 1, 1, 1, 32'h0, 32'h8000_0337, 1, 31'h4);
        add(0, 1, 1, 1, 32'h4, 32'h0003_03E7, 1, 31'h8);
        add(0, 1, 1, 1, 32'h8, 32'h0,         1, 31'hC);
        // Back-pressure: fill, freeze, then drain contiguously
        add(1, 1, 0, 0, 32'h0, 32'h0,         1, 31'h0);
        add(0, 1, 0, 1, 32'h0, 32'h8000_0337, 1, 31'h4);
        add(0, 1, 0, 1, 32'h0, 32'h8000_0337, 0, 31'h8);
        add(0, 1, 0, 1, 32'h0, 32'h8000_0337, 0, 31'h8);
        add(0, 1, 0, 1, 32'h0, 32'h8000_0337, 0, 31'h8);
        add(0, 1, 1, 1, 32'h0, 32'h8000_0337, 1, 31'h8);
        add(0, 1, 1, 1, 32'h4, 32'h0003_03E7, 1, 31'hC);
        add(0, 1, 1, 1, 32'h8, 32'h0,         1, 31'h10);
        add(0, 1, 1, 1, 32'hC, 32'h0,         1, 31'h14);
        // fetch_en 1-0-1
        add(1, 1, 1, 0, 32'h0, 32'h0,         1, 31'h0);
        add(0, 0, 1, 1, 32'h0, 32'h8000_0337, 0, 31'h4);
        add(0, 1, 1, 0, 32'h0, 32'h0,         1, 31'h4);
        add(0, 1, 1, 1, 32'h4, 32'h0003_03E7, 1, 31'h8);
        add(0, 1, 1, 1, 32'h8, 32'h0,         1, 31'hC);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before)
                do_reset();
            bus.fetch_en = tbl[i].en;
            bus.instr_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_pc", i), bus.instr_pc, tbl[i].e_pc);
            chk($sformatf("v%0d_data", i), bus.instr_data, tbl[i].e_data);
            chk($sformatf("v%0d_rom_en", i), 32'(bus.rom_en), 32'(tbl[i].e_rom_en));
            chk($sformatf("v%0d_addr", i), 32'(bus.rom_address), 32'(tbl[i].e_addr));
            next_cycle();
        end

        // Redirect to 6 with a full buffer and ready high
        do_reset();
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b0;
        next_cycle();
        next_cycle();
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0006;
        #1;
        chk("redir_full_valid", 32'(bus.instr_valid), 32'h1);
        chk("redir_rom_en", 32'(bus.rom_en), 32'h0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("redir_n1_valid", 32'(bus.instr_valid), 32'h0);
        chk("redir_n1_addr", 32'(bus.rom_address), 32'h4);
        chk("redir_n1_rom_en", 32'(bus.rom_en), 32'h1);
        next_cycle();
        #1;
        chk("redir_n2_valid", 32'(bus.instr_valid), 32'h1);
        chk("redir_n2_pc", bus.instr_pc, 32'h4);
        chk("redir_n2_data", bus.instr_data, 32'h0003_03E7);
        next_cycle();

        // Asynchronous reset mid-stream with a full buffer
        do_reset();
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        chk("full_before_rst_data", bus.instr_data, 32'h8000_0337);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("async_rst_data", bus.instr_data, 32'h0);
        chk("async_rst_pc", bus.instr_pc, 32'h0);
        chk("async_rst_rom_en", 32'(bus.rom_en), 32'h0);
        next_cycle();
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk("restart_addr", 32'(bus.rom_address), 32'h0);
        chk("restart_rom_en", 32'(bus.rom_en), 32'h1);
        next_cycle();
        #1;
        chk("restart_pc", bus.instr_pc, 32'h0);
        chk("restart_data", bus.instr_data, 32'h8000_0337);
        next_cycle();

        // PC wrap on the RESET_PC = FFFF_FFF8 instance
        do_reset();
        wbus.fetch_en = 1'b1;
        #1;
        chk("wrap_addr0", 32'(wbus.rom_address), 32'h7FFF_FFF8);
        chk("wrap_valid0", 32'(wbus.instr_valid), 32'h0);
        next_cycle();
        #1;
        chk("wrap_pc1", wbus.instr_pc, 32'hFFFF_FFF8);
        chk("wrap_addr1", 32'(wbus.rom_address), 32'h7FFF_FFFC);
        next_cycle();
        #1;
        chk("wrap_pc2", wbus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_addr2", 32'(wbus.rom_address), 32'h0);
        next_cycle();
        #1;
        chk("wrap_pc3", wbus.instr_pc, 32'h0);
        chk("wrap_data3", wbus.instr_data, 32'h8000_0337);
        wbus.fetch_en = 1'b0;
        next_cycle();

        // Random traffic against the queue model
        rom_mode = 1'b1;
        do_reset();
        q_pc.delete();
        q_ins.delete();
        m_pc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            bit en, rdy, rv, m_valid, m_pop, m_push;
            logic [31:0] rpc;
            en  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 99) < 8);
            rpc = $urandom;
            bus.fetch_en = en;
            bus.instr_ready = rdy;
            bus.redirect_valid = rv;
            bus.redirect_pc = rpc;
            #1;
            m_valid = (q_pc.size() != 0);
            m_pop   = m_valid && rdy;
            m_push  = en && ((q_pc.size() < 2) || m_pop) && !rv;
            chk($sformatf("r%0d_valid", c), 32'(bus.instr_valid), 32'(m_valid));
            chk($sformatf("r%0d_pc", c), bus.instr_pc, m_valid ? q_pc[0] : 32'h0);
            chk($sformatf("r%0d_data", c), bus.instr_data, m_valid ? q_ins[0] : 32'h0);
            chk($sformatf("r%0d_rom_en", c), 32'(bus.rom_en), 32'(m_push));
            chk($sformatf("r%0d_addr", c), 32'(bus.rom_address), {1'b0, m_pc[30:0]});
            @(posedge clk);
            if (rv) begin
                q_pc.delete();
                q_ins.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                if (m_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_ins.pop_front());
                end
                if (m_push) begin
                    q_pc.push_back(m_pc);
                    q_ins.push_back(rom_word(m_pc[30:0], 1'b1));
                    m_pc = m_pc + 32'd4;
                end
            end
            @(negedge clk);
        end
        bus.redirect_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
